// File: rtl/demux_1x4_buf.sv
// Buffered 1-to-4 demultiplexer with valid/ready on every port.
// Define DEMUX_SKID_EN for 2-entry per-channel FIFOs (registered in_ready).
module demux_1x4_buf #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
);

    // Same encoding as the 4:1 mux: in_sel[1] is the low channel bit.
    logic [1:0] ch;
    logic       push;
    logic [3:0] push_ch;
    logic [3:0] pop_ch;

    logic [3:0][WIDTH-1:0] head_q, head_d;

    assign ch   = {in_sel[0], in_sel[1]};
    assign push = in_valid & in_ready;

    always_comb begin
        push_ch = 4'b0000;
        push_ch[ch] = push;
    end

    assign pop_ch   = out_valid & out_ready;
    assign out_data = head_q;

`ifdef DEMUX_SKID_EN
    logic [3:0][WIDTH-1:0] skid_q, skid_d;
    logic [3:0][1:0]       count_q, count_d;

    // Registered-only ready: no path from out_ready to in_ready.
    assign in_ready = (count_q[ch] != 2'd2);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (count_q[k] != 2'd0);
        end
    end

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        for (int k = 0; k < 4; k++) begin
            case ({push_ch[k], pop_ch[k]})
                2'b10: begin
                    if (count_q[k] == 2'd0) begin
                        head_d[k] = in_data;
                    end else begin
                        skid_d[k] = in_data;
                    end
                    count_d[k] = count_q[k] + 2'd1;
                end
                2'b01: begin
                    head_d[k]  = skid_q[k];
                    count_d[k] = count_q[k] - 2'd1;
                end
                // Push+pop only reaches here at count 1, so the new word becomes head.
                2'b11: begin
                    head_d[k] = in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end
`else
    logic [3:0] valid_q, valid_d;

    assign in_ready  = ~valid_q[ch] | out_ready[ch];
    assign out_valid = valid_q;

    always_comb begin
        head_d  = head_q;
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            if (push_ch[k]) begin
                head_d[k]  = in_data;
                valid_d[k] = 1'b1;
            end else if (pop_ch[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Directed bench for demux_1x4_buf: routing, backpressure, push/pop, streaming, reset.
module tb_demux_1x4_buf;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;

    int checks;
    int failures;
    logic [W-1:0] exp_q[$];

    demux_1x4_buf #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] chan(input int k);
        return out_data[k*W +: W];
    endfunction

    initial begin
        logic [1:0] sel_tab [4];
        logic [W-1:0] e;
        sel_tab[0] = 2'b00;
        sel_tab[1] = 2'b10;
        sel_tab[2] = 2'b01;
        sel_tab[3] = 2'b11;
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_sel    = 2'b00;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #3;
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        rst = 1'b0;

        // Routing: each select lands in its own channel
        for (int i = 0; i < 4; i++) begin
            in_sel   = sel_tab[i];
            in_data  = W'(16'hA0 + i);
            in_valid = 1'b1;
            #1;
            chk($sformatf("route_in_ready_%0d", i), {63'd0, in_ready}, 64'd1);
            tick();
            chk($sformatf("route_valid_%0d", i), {63'd0, out_valid[i]}, 64'd1);
            chk($sformatf("route_data_%0d", i), {48'd0, chan(i)}, 64'hA0 + 64'(i));
        end
        in_valid = 1'b0;
        chk("route_all_valid", {60'd0, out_valid}, 64'hF);
        chk("route_all_data", out_data, 64'h00A3_00A2_00A1_00A0);

        // Backpressure on full channel 0
        in_sel   = 2'b00;
        in_data  = 16'hEEEE;
        in_valid = 1'b1;
        #1;
`ifdef DEMUX_SKID_EN
        chk("bp_in_ready_ch0", {63'd0, in_ready}, 64'd1);
`else
        chk("bp_in_ready_ch0", {63'd0, in_ready}, 64'd0);
`endif
        in_valid = 1'b0;
        tick();
        chk("bp_hold_ch0", {48'd0, chan(0)}, 64'hA0);
        chk("bp_hold_valid0", {63'd0, out_valid[0]}, 64'd1);
        out_ready = 4'b0001;
        #1;
        chk("bp_ready_with_pop", {63'd0, in_ready}, 64'd1);
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        chk("drain_ch1_valid", {60'd0, out_valid}, 64'hD);
        in_sel = 2'b10;
        #1;
        chk("bp_in_ready_ch1_empty", {63'd0, in_ready}, 64'd1);

        // Same-cycle push/pop on channel 2
        in_sel    = 2'b01;
        in_data   = 16'h0011;
        in_valid  = 1'b1;
        out_ready = 4'b0100;
        #1;
        chk("pp_take_old_a2", {48'd0, chan(2)}, 64'hA2);
        tick();
        chk("pp_load_11", {48'd0, chan(2)}, 64'h11);
        in_data = 16'h0022;
        #1;
        chk("pp_take_old_11", {48'd0, chan(2)}, 64'h11);
        chk("pp_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        chk("pp_load_22", {48'd0, chan(2)}, 64'h22);
        chk("pp_valid2", {63'd0, out_valid[2]}, 64'd1);
        chk("pp_ch0_untouched", {48'd0, chan(0)}, 64'hA0);

        // Streaming 16 words through channel 3
        exp_q.push_back(16'h00A3);
        in_sel    = 2'b11;
        out_ready = 4'b1000;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = W'(16'h0300 + i);
            exp_q.push_back(in_data);
            #1;
            chk($sformatf("stream_ready_%0d", i), {63'd0, in_ready}, 64'd1);
            chk($sformatf("stream_valid_%0d", i), {63'd0, out_valid[3]}, 64'd1);
            e = exp_q.pop_front();
            chk($sformatf("stream_data_%0d", i), {48'd0, chan(3)}, {48'd0, e});
            tick();
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        chk("stream_last_data", {48'd0, chan(3)}, {48'd0, e});
        tick();
        out_ready = 4'b0000;
        chk("stream_drained", {63'd0, out_valid[3]}, 64'd0);

        // Reset mid-operation
        in_valid = 1'b1;
        in_sel   = 2'b10;
        in_data  = 16'h0B01;
        tick();
        in_sel  = 2'b11;
        in_data = 16'h0B03;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", {60'd0, out_valid}, 64'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {60'd0, out_valid}, 64'd0);
        chk("async_rst_data", out_data, 64'd0);
        tick();
        rst      = 1'b0;
        in_sel   = 2'b10;
        in_data  = 16'h0055;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", {60'd0, out_valid}, 64'h2);
        chk("post_rst_data", {48'd0, chan(1)}, 64'h55);

`ifdef DEMUX_SKID_EN
        // Two-entry FIFO on channel 0 with registered ready
        in_sel    = 2'b00;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        #1;
        chk("skid_ready_cnt0", {63'd0, in_ready}, 64'd1);
        tick();
        in_data = 16'h0002;
        #1;
        chk("skid_ready_cnt1", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("skid_ready_full", {63'd0, in_ready}, 64'd0);
        out_ready = 4'b0001;
        #1;
        chk("skid_ready_no_comb", {63'd0, in_ready}, 64'd0);
        chk("skid_pop_first", {48'd0, chan(0)}, 64'h1);
        tick();
        chk("skid_pop_second", {48'd0, chan(0)}, 64'h2);
        chk("skid_valid_cnt1", {63'd0, out_valid[0]}, 64'd1);
        chk("skid_ready_after_pop", {63'd0, in_ready}, 64'd1);
        tick();
        out_ready = 4'b0000;
        chk("skid_empty", {63'd0, out_valid[0]}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demux_1x4_buf.md
# demux_1x4_buf

Buffered 1-to-4 demultiplexer with valid/ready handshakes on every port. It routes each accepted input word to one of four output channels, chosen by a 2-bit select, and holds the word in that channel until its consumer takes it. It is the distribution counterpart of the 4:1 select path: it uses the same select encoding, so a word sent with select `s` reappears on the mux input selected by `s`. It sits between a single producer, such as the result or write-back path, and up to four consumers.

## Interface
- `WIDTH`, default 32: data word width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input WIDTH: word to route.
- `in_sel` input 2: destination channel select (encoding below).
- `in_valid` input 1: producer offers `in_data`/`in_sel`.
- `in_ready` output 1: block accepts the offered word this cycle.
- `out_data` output 4*WIDTH: channel k data on bits `[k*WIDTH +: WIDTH]`.
- `out_valid` output 4: channel k holds a word.
- `out_ready` input 4: consumer k takes the word this cycle.

## Operation
- Select mapping, fixed and matching the 4:1 mux:
  - `in_sel` = 2'b00 → channel 0
  - 2'b10 → channel 1
  - 2'b01 → channel 2
  - 2'b11 → channel 3
  - `in_sel[1]` is the low-order channel bit.
- Accept (push): `in_valid & in_ready` on a rising edge. The word is written into the selected channel's buffer.
- Drain (pop): `out_valid[k] & out_ready[k]` on a rising edge. The head entry of channel k is removed.
- Default build: each channel has a 1-entry holding register.
  - `in_ready = ~out_valid[c] | out_ready[c]`, where c is the channel decoded from `in_sel`.
  - This is combinational from `in_sel` and `out_ready`.
- Non-selected channels are never written. Their contents and `out_valid` change only on their own pop.
- Push and pop on the same channel in the same cycle:
  - The pop takes the old word.
  - The new word is loaded.
  - `out_valid[c]` stays 1.
- Push to channel c while channel j≠c pops: both happen independently.
- `in_valid=0`: `in_ready` still reflects the currently selected channel. No state changes.
- Each channel is strictly in-order. There is no ordering guarantee across channels.
- `out_data[k]` is stable while `out_valid[k]=1` and `out_ready[k]=0`.
- `out_data[k]` is don't-care when `out_valid[k]=0`, but it is reset to 0.

## Timing
- Latency: a word accepted at edge N appears with `out_valid` high after edge N, i.e. in cycle N+1. There is no combinational path from input data to output data.
- Throughput: one word per cycle, provided the target channel is drained every cycle.
- Reset (async assert, release synchronous to `clk` by the environment):
  - `out_valid` = 4'b0000.
  - `out_data` = 0.
  - All skid entries are empty.
  - `in_ready` = 1 (default build) or 1 (skid build).
- Reset mid-operation: all buffered words are discarded immediately. Asserting `rst` lowers `out_valid` without a clock.

## Configuration
- Macro `DEMUX_SKID_EN`.
- Defined:
  - Each channel becomes a 2-entry FIFO: head plus skid, with a 2-bit occupancy counter (0..2).
  - `in_ready = (count[c] < 2)` uses registered state only. There is no combinational path from `out_ready` to `in_ready`.
  - Push at count 2 is impossible because `in_ready=0`.
  - Push and pop in the same cycle leave the count unchanged and preserve FIFO order.
  - Pop at count 0 is impossible because `out_valid=0`.
  - `out_valid[k] = (count[k] != 0)`.
- Undefined: the 1-entry behaviour above. Occupancy is just `out_valid[k]`.
- Latency is 1 cycle in both builds.

## Test plan
- Routing: after reset, push 0xA0, 0xA1, 0xA2, 0xA3 with `in_sel` = 00, 10, 01, 11 and all `out_ready=0` → channels 0..3 hold 0xA0..0xA3 respectively; `out_valid`=4'b1111 one cycle after each push.
- Backpressure: channel 0 full, `out_ready[0]=0`, `in_sel`=00, `in_valid=1` → `in_ready=0`; `out_data[0]` stays 0xA0. Switching `in_sel` to 10 with channel 1 empty → `in_ready=1`.
- Same-cycle push/pop: channel 2 holds 0x11; push 0x22 to channel 2 with `out_ready[2]=1` → consumer takes 0x11; next cycle channel 2 shows 0x22 with `out_valid[2]=1`.
- Streaming: 16 consecutive pushes to channel 3 with `out_ready[3]=1` → 16 words out in order, one per cycle, 1-cycle latency, `in_ready` never drops.
- Reset mid-operation: all channels valid; assert `rst` between edges → `out_valid` goes to 0 and `out_data` to 0 immediately; after release, a new push to channel 1 arrives normally.
- `DEMUX_SKID_EN`: hold `out_ready[0]=0` and push 0x1, 0x2 to channel 0 → `in_ready` goes 0 after the second push with no dependence on `out_ready`; then release → pops yield 0x1 then 0x2.
